// File: rtl/l2_conv_accum_requant.sv
// l2_conv_accum_requant
// Accumulates GROUPS signed partial sums from the L2 adder tree per output
// pixel, adds a per-pixel bias on the first beat, then applies ReLU,
// round-half-up right shift and unsigned saturation. Emits one activation
// per pixel with a single-cycle valid pulse.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   vbit_i     partial-sum beat valid (no backpressure)
//   data_i     signed partial sum
//   bias_i     signed bias, used on the first beat of a pixel only
//   clr_i      synchronous abort of the current pixel
//   data_o     unsigned activation (registered, holds while vbit_o=0)
//   vbit_o     one-cycle pulse per completed pixel
//   grp_cnt_o  beats received for the current pixel
module l2_conv_accum_requant #(
  parameter int unsigned IN_W   = 22,
  parameter int unsigned GROUPS = 4,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned ACC_W  = 25,
  parameter int unsigned SHIFT  = 8,
  parameter int unsigned OUT_W  = 8,
  localparam int unsigned CNT_W = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vbit_i,
  input  logic [IN_W-1:0]   data_i,
  input  logic [BIAS_W-1:0] bias_i,
  input  logic              clr_i,
  output logic [OUT_W-1:0]  data_o,
  output logic              vbit_o,
  output logic [CNT_W-1:0]  grp_cnt_o
);

  // One extra bit so the rounding constant cannot overflow a positive sum
  localparam int unsigned RW       = ACC_W + 1;
  localparam int unsigned SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [RW-1:0] RND     = (SHIFT > 0) ? (RW'(1) << SHIFT_M1) : RW'(0);
  localparam logic [RW-1:0] OUT_MAX = RW'((64'd1 << OUT_W) - 64'd1);
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]        grp_cnt, grp_cnt_nxt;
  logic [OUT_W-1:0]        data_nxt;
  logic                    vbit_nxt;

  logic signed [ACC_W-1:0] base_c;
  logic signed [ACC_W-1:0] sum_c;
  logic [RW-1:0]           rounded_c;
  logic [RW-1:0]           shifted_c;
  logic [OUT_W-1:0]        q_c;

  // Running sum including the current beat; bias replaces acc on group 0
  always_comb begin
    base_c = (grp_cnt == '0) ? ACC_W'($signed(bias_i)) : acc;
    sum_c  = base_c + ACC_W'($signed(data_i));
  end

  // Requantisation: ReLU, round-half-up shift, unsigned saturation
  always_comb begin
    rounded_c = {1'b0, sum_c} + RND;
    shifted_c = rounded_c >> SHIFT;
    q_c       = '0;
    if (!sum_c[ACC_W-1] && (sum_c != '0)) begin
      if (shifted_c > OUT_MAX) q_c = OUT_MAX[OUT_W-1:0];
      else                     q_c = shifted_c[OUT_W-1:0];
    end
  end

  // Next-state: clr_i beats a coincident beat; data_o holds unless a pixel ends
  always_comb begin
    acc_nxt     = acc;
    grp_cnt_nxt = grp_cnt;
    data_nxt    = data_o;
    vbit_nxt    = 1'b0;
    if (clr_i) begin
      acc_nxt     = '0;
      grp_cnt_nxt = '0;
    end else if (vbit_i) begin
      if (grp_cnt == LAST_GRP) begin
        acc_nxt     = '0;
        grp_cnt_nxt = '0;
        data_nxt    = q_c;
        vbit_nxt    = 1'b1;
      end else begin
        acc_nxt     = sum_c;
        grp_cnt_nxt = grp_cnt + CNT_W'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      grp_cnt <= '0;
      data_o  <= '0;
      vbit_o  <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      grp_cnt <= grp_cnt_nxt;
      data_o  <= data_nxt;
      vbit_o  <= vbit_nxt;
    end
  end

  assign grp_cnt_o = grp_cnt;

endmodule

// File: tb/tb_l2_conv_accum_requant.sv
// Directed bench for l2_conv_accum_requant with default parameters
// (GROUPS=4, SHIFT=8, OUT_W=8). Inputs change on the falling edge,
// outputs are checked 1 time unit after the rising edge.
module tb_l2_conv_accum_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic        vbit_i;
  logic [21:0] data_i;
  logic [15:0] bias_i;
  logic        clr_i;
  logic [7:0]  data_o;
  logic        vbit_o;
  logic [1:0]  grp_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  int p0;

  l2_conv_accum_requant dut (
    .clk       (clk),
    .rst       (rst),
    .vbit_i    (vbit_i),
    .data_i    (data_i),
    .bias_i    (bias_i),
    .clr_i     (clr_i),
    .data_o    (data_o),
    .vbit_o    (vbit_o),
    .grp_cnt_o (grp_cnt_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (vbit_o === 1'b1) pulses++;

  // One clock: apply inputs on the falling edge, settle after the rising edge
  task automatic step(input logic r, input logic v, input int d, input int b, input logic c);
    @(negedge clk);
    rst    = r;
    vbit_i = v;
    data_i = 22'(d);
    bias_i = 16'(b);
    clr_i  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic beat(input int d, input int b);
    step(1'b0, 1'b1, d, b, 1'b0);
  endtask

  initial begin
    rst = 1'b1; vbit_i = 1'b0; data_i = '0; bias_i = '0; clr_i = 1'b0;
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 77, 5, 1'b0);
    chk("rst_data", int'(data_o), 0);
    chk("rst_vbit", int'(vbit_o), 0);
    chk("rst_grp", int'(grp_cnt_o), 0);

    // 1: sum 10256 -> 40, bias applied once only
    idle();
    chk("t1_grp0", int'(grp_cnt_o), 0);
    beat(1000, 256); chk("t1_grp1", int'(grp_cnt_o), 1); chk("t1_v1", int'(vbit_o), 0);
    beat(2000, 256); chk("t1_grp2", int'(grp_cnt_o), 2);
    beat(3000, 256); chk("t1_grp3", int'(grp_cnt_o), 3);
    beat(4000, 256);
    chk("t1_grp_wrap", int'(grp_cnt_o), 0);
    chk("t1_vbit", int'(vbit_o), 1);
    chk("t1_data", int'(data_o), 40);
    idle();
    chk("t1_vbit_drop", int'(vbit_o), 0);
    chk("t1_data_hold", int'(data_o), 40);

    // 2: round-half-up boundary
    beat(384, 0); beat(0, 0); beat(0, 0); beat(0, 0);
    chk("t2_half_up", int'(data_o), 2);
    beat(383, 0); beat(0, 0); beat(0, 0); beat(0, 0);
    chk("t2_below_half", int'(data_o), 1);

    // 3: ReLU and saturation
    for (int i = 0; i < 4; i++) beat(-500, 0);
    chk("t3_relu_data", int'(data_o), 0);
    chk("t3_relu_vbit", int'(vbit_o), 1);
    for (int i = 0; i < 4; i++) beat(20000, 0);
    chk("t3_sat", int'(data_o), 255);

    // 4: gapped pixel A, then back-to-back pixel B
    idle();
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      beat(256, 0);
      if (i < 3) begin
        idle(); idle(); idle();
        chk("t4_gap_grp", int'(grp_cnt_o), i + 1);
        chk("t4_gap_vbit", int'(vbit_o), 0);
      end
    end
    chk("t4_a_data", int'(data_o), 4);
    chk("t4_a_vbit", int'(vbit_o), 1);
    beat(512, 0);
    chk("t4_b1_vbit", int'(vbit_o), 0);
    beat(512, 0); beat(512, 0); beat(512, 0);
    chk("t4_b_data", int'(data_o), 8);
    chk("t4_b_vbit", int'(vbit_o), 1);
    idle();
    chk("t4_pulses", pulses - p0, 2);

    // 5: clr_i with 3rd beat, with final beat, and after final beat
    p0 = pulses;
    beat(256, 0); beat(256, 0);
    step(1'b0, 1'b1, 256, 0, 1'b1);
    chk("t5_clr_grp", int'(grp_cnt_o), 0);
    chk("t5_clr_vbit", int'(vbit_o), 0);
    for (int i = 0; i < 4; i++) beat(256, 0);
    chk("t5_after_clr", int'(data_o), 4);
    chk("t5_after_vbit", int'(vbit_o), 1);
    beat(100, 0); beat(100, 0); beat(100, 0);
    step(1'b0, 1'b1, 100, 0, 1'b1);
    chk("t5_clr_final_vbit", int'(vbit_o), 0);
    chk("t5_clr_final_data", int'(data_o), 4);
    for (int i = 0; i < 4; i++) beat(768, 0);
    chk("t5_pre_clr_vbit", int'(vbit_o), 1);
    chk("t5_pre_clr_data", int'(data_o), 12);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    chk("t5_post_clr_grp", int'(grp_cnt_o), 0);
    idle();
    chk("t5_pulses", pulses - p0, 2);

    // 6: reset mid-pixel
    beat(1000, 50); beat(1000, 50);
    chk("t6_pre_grp", int'(grp_cnt_o), 2);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("t6_rst_data", int'(data_o), 0);
    chk("t6_rst_vbit", int'(vbit_o), 0);
    chk("t6_rst_grp", int'(grp_cnt_o), 0);
    p0 = pulses;
    for (int i = 0; i < 4; i++) beat(1280, 0);
    chk("t6_data", int'(data_o), 20);
    chk("t6_vbit", int'(vbit_o), 1);
    idle();
    chk("t6_pulses", pulses - p0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l2_conv_accum_requant.md
Name: l2_conv_accum_requant

Overview:
- Sits directly downstream of the L2 convolution adder tree.
- Consumes the tree's registered 22-bit signed partial sums, one per input-channel group.
- Accumulates GROUPS consecutive partial sums per output pixel and adds a per-pixel bias.
- Applies ReLU, round-half-up right shift and unsigned saturation, then emits one 8-bit activation per pixel with a valid pulse, for the L2 output buffer.

Parameters:
IN_W, 22, width of signed partial-sum input (matches adder-tree output)
GROUPS, 4, partial sums accumulated per output pixel (>=1)
BIAS_W, 16, width of signed bias input
ACC_W, 25, accumulator width; must be >= max(IN_W,BIAS_W)+clog2(GROUPS)+1 (no overflow by construction)
SHIFT, 8, requantisation right shift (0 = no shift, no rounding)
OUT_W, 8, unsigned output activation width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
vbit_i  input  1  partial sum valid (single-cycle per beat, no backpressure)
data_i  input  IN_W  signed partial sum
bias_i  input  BIAS_W  signed bias; sampled only on the first beat of a pixel
clr_i  input  1  synchronous abort of current pixel accumulation
data_o  output  OUT_W  unsigned activation
vbit_o  output  1  data_o valid, one-cycle pulse per completed pixel
grp_cnt_o  output  clog2(GROUPS) (min 1)  current group index (beats received for current pixel)

Behaviour:
- Reset values:
  - rst=1 on a clock edge: acc=0, grp_cnt=0, data_o=0, vbit_o=0.
  - rst overrides all other inputs.
- Accumulate:
  - On vbit_i=1 with grp_cnt==0: acc <= sext(data_i)+sext(bias_i).
  - On vbit_i=1 with 0<grp_cnt<GROUPS-1: acc <= acc+sext(data_i).
  - grp_cnt increments on each accepted beat.
- Final beat:
  - On vbit_i=1 with grp_cnt==GROUPS-1: sum = acc+sext(data_i); for GROUPS=1, sum = sext(data_i)+sext(bias_i).
  - grp_cnt wraps to 0.
  - The same edge registers the requantised result: data_o <= q(sum), vbit_o <= 1.
- Latency: vbit_o asserts exactly 1 cycle after the final beat's clock edge.
  - Back-to-back pixels are allowed, with no bubble needed.
  - Throughput is 1 beat/cycle.
- Gaps: when vbit_i=0, acc and grp_cnt hold; gaps between beats of a pixel are unlimited.
- Output hold: vbit_o is low on all other cycles; data_o holds its last value while vbit_o=0.
- q(sum):
  - If sum<=0, result is 0 (ReLU).
  - Otherwise, if SHIFT>0, r = (sum + 2^(SHIFT-1)) >>> SHIFT; if SHIFT=0, r = sum.
  - data_o = min(r, 2^OUT_W-1).
- clr_i=1 (and rst=0):
  - Next state is acc=0, grp_cnt=0.
  - A vbit_i beat in the same cycle is discarded; clr_i has priority.
  - clr_i does not cancel a vbit_o already registered. If clr_i coincides with a final beat, no output is produced for that pixel.
- Counter wrap: grp_cnt never reaches GROUPS; values above GROUPS-1 are unreachable.
- Reset mid-pixel: the partial accumulation is lost; the next beat after rst deasserts is treated as group 0.

Test Plan:
1. GROUPS=4, SHIFT=8, bias 256; beats 1000,2000,3000,4000 on consecutive cycles -> one cycle after the 4th beat: vbit_o=1, data_o=40 (sum 10256); grp_cnt_o sequence 0,1,2,3,0.
2. Round-half-up: bias 0; beats 384,0,0,0 -> data_o=2. Beats 383,0,0,0 -> data_o=1.
3. ReLU and saturation:
   - Beats -500 x4, bias 0 -> data_o=0, vbit_o=1.
   - Beats 20000 x4, bias 0 -> data_o=255.
4. Gapped input and back-to-back pixels:
   - Pixel A (bias 0, beats 256 x4) with 3 idle cycles between beats -> data_o=4, one pulse.
   - Pixel B (bias 0, beats 512 x4) starts on the cycle after A's last beat -> data_o=8 one cycle after B's last beat.
   - Exactly 2 vbit_o pulses total.
5. clr_i:
   - Assert clr_i together with the 3rd beat of a pixel -> no vbit_o. grp_cnt_o=0 next cycle.
   - Next 4 beats (bias 0, 256 x4) -> data_o=4.
   - Assert clr_i the cycle after a final beat -> that vbit_o still pulses.
6. Reset: assert rst after 2 beats -> data_o=0, vbit_o=0, grp_cnt_o=0. After release, a full 4-beat pixel produces the correct single output.
